// File: rtl/lsu_mem_bridge_if.sv
// Handshake and RAM-port bundle between the execute stage, the LSU bridge
// and the data-memory port. The bridge uses the slave view; the environment
// (execute stage plus RAM) uses the master view.
interface lsu_mem_bridge_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_wen;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_valid;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_addr, req_wdata, req_wen, req_size, req_unsigned,
    input  resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_valid, mem_wen, mem_addr, mem_wdata, mem_wmask
  );

  modport master (
    output req_valid, req_addr, req_wdata, req_wen, req_size, req_unsigned,
    output resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_valid, mem_wen, mem_addr, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/lsu_mem_bridge.sv
// Load/store bridge in front of the data RAM: one access at a time, lane
// mask/data generation, fixed-length RAM request, load extract and extend.
//
//   state  | meaning
//   IDLE   | ready for a request; latches it on accept
//   ACCESS | mem_valid held for LATENCY cycles; write commits on last cycle
//   RESP   | response presented until resp_ready
module lsu_mem_bridge #(
  parameter int unsigned LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset,
  lsu_mem_bridge_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        wen_q, wen_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        req_bad;
  logic [3:0]  lane_mask;
  logic [31:0] rd_shift;
  logic [31:0] load_ext;

  // State and datapath registers; reset abandons any access in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wen_q   <= 1'b0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wen_q   <= wen_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Illegal size or misaligned address on the incoming request.
  always_comb begin
    req_bad = (bus.req_size == 2'd3) ||
              (bus.req_size == 2'd1 && bus.req_addr[0]) ||
              (bus.req_size == 2'd2 && bus.req_addr[1:0] != 2'b00);
  end

  // Lane mask and load extraction from the latched request.
  always_comb begin
    case (size_q)
      2'd0:    lane_mask = 4'b0001 << addr_q[1:0];
      2'd1:    lane_mask = 4'b0011 << addr_q[1:0];
      default: lane_mask = 4'b1111;
    endcase
    rd_shift = bus.mem_rdata >> {addr_q[1:0], 3'b000};
    case (size_q)
      2'd0:    load_ext = {{24{~uns_q & rd_shift[7]}}, rd_shift[7:0]};
      2'd1:    load_ext = {{16{~uns_q & rd_shift[15]}}, rd_shift[15:0]};
      default: load_ext = rd_shift;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.req_valid) state_d = req_bad ? RESP : ACCESS;
      ACCESS:  if (cnt_q == 4'd0) state_d = RESP;
      RESP:    if (bus.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath register updates: latch on accept, count down, capture result.
  always_comb begin
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wen_d   = wen_q;
    size_d  = size_q;
    uns_d   = uns_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          wen_d   = bus.req_wen;
          size_d  = bus.req_size;
          uns_d   = bus.req_unsigned;
          cnt_d   = 4'(LATENCY - 1);
          err_d   = req_bad;
          rdata_d = '0;
          case (bus.req_size)
            2'd0:    wdata_d = {4{bus.req_wdata[7:0]}};
            2'd1:    wdata_d = {2{bus.req_wdata[15:0]}};
            default: wdata_d = bus.req_wdata;
          endcase
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) rdata_d = wen_q ? 32'd0 : load_ext;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP: begin
        if (bus.resp_ready) begin
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Outputs decoded from the current state; write enable only on the last beat.
  always_comb begin
    bus.req_ready  = (state_q == IDLE);
    bus.mem_valid  = (state_q == ACCESS);
    bus.mem_wen    = (state_q == ACCESS) && (cnt_q == 4'd0) && wen_q;
    bus.mem_wmask  = (state_q == ACCESS) ? lane_mask : 4'b0000;
    bus.mem_addr   = addr_q;
    bus.mem_wdata  = wdata_q;
    bus.resp_valid = (state_q == RESP);
    bus.resp_rdata = rdata_q;
    bus.resp_err   = err_q;
  end

endmodule

// File: tb/tb_lsu_mem_bridge.sv
// Self-checking bench for lsu_mem_bridge: directed cases plus random
// requests against a byte-level memory model.
module tb_lsu_mem_bridge;
  localparam int unsigned LAT = 3;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  lsu_mem_bridge_if bus ();
  lsu_mem_bridge #(.LATENCY(LAT)) dut (.clock(clock), .reset(reset), .bus(bus));

  // RAM behaviour: masked read lanes, masked write on mem_wen.
  logic [31:0] ram [16];
  logic        init_we = 1'b0;
  logic [3:0]  init_idx = '0;
  logic [31:0] init_data = '0;

  always @(posedge clock) begin
    if (init_we) ram[init_idx] <= init_data;
    else if (bus.mem_valid && bus.mem_wen)
      for (int i = 0; i < 4; i++)
        if (bus.mem_wmask[i]) ram[bus.mem_addr[5:2]][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
  end

  always_comb begin
    bus.mem_rdata = '0;
    if (bus.mem_valid)
      for (int i = 0; i < 4; i++)
        if (bus.mem_wmask[i]) bus.mem_rdata[8*i +: 8] = ram[bus.mem_addr[5:2]][8*i +: 8];
  end

  logic [31:0] model [16];
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_err(input int o, input int size);
    return (size == 3) || (size == 1 && (o % 2) != 0) || (size == 2 && o != 0);
  endfunction

  function automatic logic [3:0] exp_mask(input int o, input int size);
    int m;
    m = (size == 0) ? 1 : (size == 1) ? 3 : 15;
    return 4'(m << o);
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [31:0] wd, input int size);
    if (size == 0) return (wd % 256) * 32'h0101_0101;
    if (size == 1) return (wd % 65536) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] w, input int o, input int size, input bit uns);
    logic [31:0] v;
    v = w >> (8 * o);
    if (size == 0) begin
      v = v % 256;
      if (!uns && v >= 128) v = v - 256;
    end else if (size == 1) begin
      v = v % 65536;
      if (!uns && v >= 32768) v = v - 65536;
    end
    return v;
  endfunction

  task automatic do_req(input logic [31:0] addr, input logic [31:0] wdata, input bit wen,
                        input int size, input bit uns, input int hold);
    int o, idx, nv, nw, wen_at;
    bit err;
    logic [3:0] emask, seen_mask;
    logic [31:0] ewd, erd, seen_wd, seen_addr, store_word;
    o = int'(addr[1:0]);
    idx = int'(addr[5:2]);
    err = exp_err(o, size);
    emask = exp_mask(o, size);
    ewd = exp_wdata(wdata, size);
    erd = (err || wen) ? 32'd0 : exp_load(model[idx], o, size, uns);
    nv = 0; nw = 0; wen_at = 0;
    seen_mask = '0; seen_wd = '0; seen_addr = '0;

    check("req_ready_idle", {31'd0, bus.req_ready}, 1);
    bus.req_valid = 1'b1;
    bus.req_addr = addr;
    bus.req_wdata = wdata;
    bus.req_wen = wen;
    bus.req_size = 2'(size);
    bus.req_unsigned = uns;
    @(negedge clock);
    bus.req_valid = 1'b0;
    bus.req_addr = $urandom;
    bus.req_wdata = $urandom;
    bus.req_wen = 1'($urandom);
    bus.req_size = 2'($urandom);
    bus.req_unsigned = 1'($urandom);

    for (int c = 0; c < 50 && !bus.resp_valid; c++) begin
      if (bus.mem_valid) begin
        nv++;
        seen_mask = bus.mem_wmask;
        seen_wd = bus.mem_wdata;
        seen_addr = bus.mem_addr;
        if (bus.mem_wen) begin
          nw++;
          wen_at = nv;
        end
      end
      @(negedge clock);
    end

    check("resp_valid", {31'd0, bus.resp_valid}, 1);
    check("mem_valid_cycles", nv, err ? 0 : LAT);
    check("mem_wen_cycles", nw, (wen && !err) ? 1 : 0);
    if (wen && !err) check("mem_wen_last_beat", wen_at, LAT);
    if (!err) begin
      check("mem_wmask", {28'd0, seen_mask}, {28'd0, emask});
      check("mem_addr", seen_addr, addr);
      if (wen) check("mem_wdata", seen_wd, ewd);
    end
    check("resp_rdata", bus.resp_rdata, erd);
    check("resp_err", {31'd0, bus.resp_err}, {31'd0, err});
    check("req_ready_resp", {31'd0, bus.req_ready}, 0);

    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      check("hold_resp_valid", {31'd0, bus.resp_valid}, 1);
      check("hold_resp_rdata", bus.resp_rdata, erd);
      check("hold_resp_err", {31'd0, bus.resp_err}, {31'd0, err});
      check("hold_req_ready", {31'd0, bus.req_ready}, 0);
    end

    bus.resp_ready = 1'b1;
    @(negedge clock);
    bus.resp_ready = 1'b0;
    check("resp_valid_after_hs", {31'd0, bus.resp_valid}, 0);
    check("req_ready_after_hs", {31'd0, bus.req_ready}, 1);

    if (wen && !err) begin
      store_word = model[idx];
      for (int i = 0; i < 4; i++)
        if (emask[i]) store_word[8*i +: 8] = ewd[8*i +: 8];
      model[idx] = store_word;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    int sz;
    bus.req_valid = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.req_wen = 1'b0;
    bus.req_size = '0;
    bus.req_unsigned = 1'b0;
    bus.resp_ready = 1'b0;

    // Load RAM and model while reset is held.
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      init_we = 1'b1;
      init_idx = 4'(i);
      init_data = (i == 0) ? 32'h8899_AABB : $urandom;
      model[i] = init_data;
    end
    @(negedge clock);
    init_we = 1'b0;

    check("rst_req_ready", {31'd0, bus.req_ready}, 1);
    check("rst_mem_valid", {31'd0, bus.mem_valid}, 0);
    check("rst_mem_wen", {31'd0, bus.mem_wen}, 0);
    check("rst_mem_wmask", {28'd0, bus.mem_wmask}, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_resp_valid", {31'd0, bus.resp_valid}, 0);
    check("rst_resp_rdata", bus.resp_rdata, 0);
    check("rst_resp_err", {31'd0, bus.resp_err}, 0);
    reset = 1'b1;
    @(negedge clock);

    // Directed loads from 0x8899AABB.
    do_req(BASE + 2, 32'h0, 1'b0, 0, 1'b0, 0);
    do_req(BASE + 2, 32'h0, 1'b0, 1, 1'b1, 0);
    do_req(BASE + 0, 32'h0, 1'b0, 2, 1'b0, 0);
    do_req(BASE + 3, 32'h0, 1'b0, 0, 1'b1, 0);
    // Byte store then word readback.
    do_req(BASE + 1, 32'h1234_565A, 1'b1, 0, 1'b0, 0);
    do_req(BASE + 0, 32'h0, 1'b0, 2, 1'b0, 0);
    check("store_readback_model", model[0], 32'h8899_5ABB);
    // Half store to upper lanes.
    do_req(BASE + 6, 32'hDEAD_BEEF, 1'b1, 1, 1'b0, 1);
    do_req(BASE + 4, 32'h0, 1'b0, 2, 1'b0, 0);
    // Errors: misaligned half, misaligned word, illegal size, misaligned store.
    do_req(BASE + 3, 32'h0, 1'b0, 1, 1'b0, 0);
    do_req(BASE + 2, 32'h0, 1'b0, 2, 1'b0, 0);
    do_req(BASE + 0, 32'h0, 1'b0, 3, 1'b0, 0);
    do_req(BASE + 1, 32'hFFFF_FFFF, 1'b1, 2, 1'b0, 0);
    // Backpressure for five cycles.
    do_req(BASE + 8, 32'h0, 1'b0, 1, 1'b0, 5);

    // resp_ready while idle is ignored.
    bus.resp_ready = 1'b1;
    repeat (2) @(negedge clock);
    check("idle_resp_ready_valid", {31'd0, bus.resp_valid}, 0);
    check("idle_resp_ready_ready", {31'd0, bus.req_ready}, 1);
    bus.resp_ready = 1'b0;

    // Reset during the final write beat: nothing commits, no response.
    bus.req_valid = 1'b1;
    bus.req_addr = BASE + 12;
    bus.req_wdata = 32'hCAFE_F00D;
    bus.req_wen = 1'b1;
    bus.req_size = 2'd2;
    bus.req_unsigned = 1'b0;
    @(negedge clock);
    bus.req_valid = 1'b0;
    repeat (LAT - 1) @(negedge clock);
    check("pre_rst_mem_wen", {31'd0, bus.mem_wen}, 1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_mem_valid", {31'd0, bus.mem_valid}, 0);
    check("mid_rst_mem_wen", {31'd0, bus.mem_wen}, 0);
    check("mid_rst_req_ready", {31'd0, bus.req_ready}, 1);
    check("mid_rst_resp_valid", {31'd0, bus.resp_valid}, 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("post_rst_resp_valid", {31'd0, bus.resp_valid}, 0);
    do_req(BASE + 12, 32'h0, 1'b0, 2, 1'b0, 0);

    // Random traffic; mostly aligned, some misaligned or illegal.
    for (int n = 0; n < 40; n++) begin
      sz = int'($urandom_range(0, 3));
      a = BASE + $urandom_range(0, 63);
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 1) a[0] = 1'b0;
        if (sz == 2) a[1:0] = 2'b00;
      end
      do_req(a, $urandom, 1'($urandom), sz, 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
